// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR receive path: widths, packet framing,
// the receiver state type and the keystream next-state rule.
package lfsr_pkg;

    localparam int DW     = 8;
    localparam int LFSR_W = 5;
    localparam int PKT_LEN = 32;
    localparam int CW     = 6;
    localparam logic [DW-1:0] PRE_CHAR = 8'h5F;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD
    } rx_state_t;

    // Shift left, feeding back the parity of the tapped state bits.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] state,
                                                    input logic [LFSR_W-1:0] taps);
        return {state[LFSR_W-2:0], ^(state & taps)};
    endfunction

endpackage

// File: rtl/lfsr5.sv
// 5-bit Fibonacci-style LFSR: loads a start value on init, otherwise steps
// once per enabled cycle using the supplied tap pattern.
module lfsr5
    import lfsr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              init,
    input  logic [LFSR_W-1:0] taps,
    input  logic [LFSR_W-1:0] start,
    output logic [LFSR_W-1:0] state
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= '0;
        end else if (init) begin
            state <= start;
        end else if (en) begin
            state <= lfsr_next(state, taps);
        end
    end

endmodule

// File: rtl/lfsr_decrypt_rx.sv
// Receive-side decryptor: regenerates the LFSR keystream, checks and strips
// the preamble, and forwards decrypted payload bytes through a one-entry register.
module lfsr_decrypt_rx
    import lfsr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_load,
    input  logic [LFSR_W-1:0] cfg_taps,
    input  logic [LFSR_W-1:0] cfg_seed,
    input  logic [3:0]        cfg_pre_len,
    input  logic              enc_valid,
    input  logic [DW-1:0]     enc_byte,
    output logic              enc_ready,
    output logic              plain_valid,
    input  logic              plain_ready,
    output logic [DW-1:0]     plain_byte,
    output logic [CW-1:0]     byte_count,
    output logic              pre_err,
    output logic              pkt_done,
    output logic              busy
);

    rx_state_t         state;
    logic [LFSR_W-1:0] taps_q;
    logic [3:0]        pre_len_q;
    logic [LFSR_W-1:0] lfsr;
    logic              accept;
    logic              pop;
    logic [DW-1:0]     dec_byte;
    logic [CW-1:0]     cnt_next;

    assign busy      = (state != IDLE);
    // A full output register only admits a new byte if it is drained this cycle.
    assign enc_ready = busy && (!plain_valid || plain_ready);
    assign accept    = enc_valid && enc_ready;
    assign pop       = plain_valid && plain_ready;
    assign dec_byte  = enc_byte ^ {{(DW-LFSR_W){1'b0}}, lfsr};
    assign cnt_next  = byte_count + CW'(1);

    lfsr5 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (accept),
        .init  (cfg_load),
        .taps  (taps_q),
        .start (cfg_seed),
        .state (lfsr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            taps_q      <= '0;
            pre_len_q   <= '0;
            plain_valid <= 1'b0;
            plain_byte  <= '0;
            byte_count  <= '0;
            pre_err     <= 1'b0;
            pkt_done    <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            if (cfg_load) begin
                // A load aborts any packet in flight without reporting completion.
                taps_q      <= cfg_taps;
                pre_len_q   <= cfg_pre_len;
                byte_count  <= '0;
                pre_err     <= 1'b0;
                plain_valid <= 1'b0;
                state       <= (cfg_pre_len == 4'd0) ? PAYLOAD : PREAMBLE;
            end else begin
                if (pop) begin
                    plain_valid <= 1'b0;
                end
                if (accept) begin
                    byte_count <= cnt_next;
                    unique case (state)
                        PREAMBLE: begin
                            if (dec_byte != PRE_CHAR) begin
                                pre_err <= 1'b1;
                            end
                            if (cnt_next == CW'(pre_len_q)) begin
                                state <= PAYLOAD;
                            end
                        end
                        PAYLOAD: begin
                            plain_byte  <= dec_byte;
                            plain_valid <= 1'b1;
                            if (cnt_next == CW'(PKT_LEN)) begin
                                pkt_done <= 1'b1;
                                state    <= IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_decrypt_rx.sv
// Self-checking bench: plaintext packets are encrypted by a bench-side keystream
// model and every output is compared each cycle against a packet-level model.
module tb_lfsr_decrypt_rx;
    import lfsr_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_load;
    logic [LFSR_W-1:0] cfg_taps;
    logic [LFSR_W-1:0] cfg_seed;
    logic [3:0]        cfg_pre_len;
    logic              enc_valid;
    logic [DW-1:0]     enc_byte;
    logic              enc_ready;
    logic              plain_valid;
    logic              plain_ready;
    logic [DW-1:0]     plain_byte;
    logic [CW-1:0]     byte_count;
    logic              pre_err;
    logic              pkt_done;
    logic              busy;

    lfsr_decrypt_rx dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_load    (cfg_load),
        .cfg_taps    (cfg_taps),
        .cfg_seed    (cfg_seed),
        .cfg_pre_len (cfg_pre_len),
        .enc_valid   (enc_valid),
        .enc_byte    (enc_byte),
        .enc_ready   (enc_ready),
        .plain_valid (plain_valid),
        .plain_ready (plain_ready),
        .plain_byte  (plain_byte),
        .byte_count  (byte_count),
        .pre_err     (pre_err),
        .pkt_done    (pkt_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Packet under test: original plaintext and its encrypted image.
    logic [7:0] orig [PKT_LEN];
    logic [7:0] enc  [PKT_LEN];

    // Packet-level expectations.
    int         m_cnt;
    int         m_pre_len;
    bit         m_busy;
    bit         m_full;
    bit         m_pre_err;
    bit         m_done;
    logic [7:0] m_byte;

    int         beats;
    bit         got_first;
    logic [7:0] first_byte;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_pre_len = 0; m_busy = 0; m_full = 0;
        m_pre_err = 0; m_done = 0; m_byte = '0;
    endtask

    // Builds plaintext (preamble chars then random payload) and encrypts it with
    // the keystream: key(i) is the register value after i steps from the seed.
    task automatic make_packet(input int taps, input int seed, input int pre_len, input int corrupt);
        int s;
        s = seed;
        for (int i = 0; i < PKT_LEN; i++) begin
            orig[i] = (i < pre_len) ? PRE_CHAR : 8'($urandom);
            if (i == corrupt) orig[i] = orig[i] ^ 8'h01;
            enc[i] = orig[i] ^ 8'(s);
            s = ((s << 1) | ($countones(s & taps) % 2)) & 31;
        end
    endtask

    // One clock: compare at negedge, then advance the model across the posedge.
    task automatic tick();
        bit fire;
        bit pop;
        bit exp_ready;
        @(negedge clk);
        exp_ready = m_busy && (!m_full || plain_ready);
        if (!rst) begin
            check("enc_ready", 32'(enc_ready), 32'(exp_ready));
            check("busy", 32'(busy), 32'(m_busy));
            check("byte_count", 32'(byte_count), 32'(m_cnt));
            check("pre_err", 32'(pre_err), 32'(m_pre_err));
            check("pkt_done", 32'(pkt_done), 32'(m_done));
            check("plain_valid", 32'(plain_valid), 32'(m_full));
            if (m_full) check("plain_byte", 32'(plain_byte), 32'(m_byte));
            if (plain_valid && plain_ready) begin
                beats++;
                if (!got_first) first_byte = plain_byte;
                got_first = 1;
            end
        end
        fire = enc_valid && exp_ready && !cfg_load && !rst;
        pop  = m_full && plain_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else if (cfg_load) begin
            m_cnt = 0; m_pre_err = 0; m_busy = 1; m_full = 0; m_done = 0;
            m_pre_len = int'(cfg_pre_len);
        end else begin
            m_done = 0;
            if (fire && m_cnt >= m_pre_len) begin
                m_byte = orig[m_cnt];
                m_full = 1;
            end else if (pop) begin
                m_full = 0;
            end
            if (fire) begin
                if (m_cnt < m_pre_len && orig[m_cnt] != PRE_CHAR) m_pre_err = 1;
                m_cnt++;
                if (m_cnt == PKT_LEN) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end
    endtask

    task automatic do_cfg(input int taps, input int seed, input int pre_len);
        enc_valid   = 1'b0;
        plain_ready = 1'b0;
        cfg_taps    = LFSR_W'(taps);
        cfg_seed    = LFSR_W'(seed);
        cfg_pre_len = 4'(pre_len);
        cfg_load    = 1'b1;
        tick();
        cfg_load  = 1'b0;
        beats     = 0;
        got_first = 0;
    endtask

    // Random valid/ready traffic until stop bytes are consumed; optionally forces
    // a five-cycle back-pressure window once the output register is full.
    task automatic run_packet(input int stop, input int stall_at);
        int guard = 0;
        bit stalled = 0;
        while (m_cnt < stop && guard < 3000) begin
            if (m_cnt == stall_at && !stalled) begin
                stalled = 1;
                enc_valid = 1'b1;
                plain_ready = 1'b0;
                while (!m_full && guard < 3000) begin
                    enc_byte = enc[m_cnt];
                    tick();
                    guard++;
                end
                repeat (5) begin
                    enc_byte = enc[m_cnt];
                    tick();
                end
            end
            enc_valid   = ($urandom % 4) != 0;
            enc_byte    = enc[m_cnt];
            plain_ready = ($urandom % 4) != 0;
            tick();
            guard++;
        end
        check("progress", 32'(m_cnt), 32'(stop));
    endtask

    task automatic drain();
        enc_valid   = 1'b0;
        plain_ready = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1; cfg_load = 1'b0; cfg_taps = '0; cfg_seed = '0; cfg_pre_len = '0;
        enc_valid = 1'b0; enc_byte = '0; plain_ready = 1'b0;
        beats = 0; got_first = 0; first_byte = '0;
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("reset_plain_byte", 32'(plain_byte), 32'h0);
        check("reset_enc_ready", 32'(enc_ready), 32'h0);

        // Clean packet, 7-byte preamble.
        make_packet(5'h1E, 5'h01, 7, -1);
        check("model_enc0", 32'(enc[0]), 32'h5E);
        check("model_enc1", 32'(enc[1]), 32'h5D);
        do_cfg(5'h1E, 5'h01, 7);
        run_packet(32, -1);
        drain();
        check("t1_beats", 32'(beats), 32'd25);
        check("t1_pre_err", 32'(pre_err), 32'h0);

        // Third preamble byte corrupted.
        make_packet(5'h1E, 5'h01, 7, 2);
        do_cfg(5'h1E, 5'h01, 7);
        run_packet(32, -1);
        drain();
        check("t2_beats", 32'(beats), 32'd25);
        check("t2_pre_err_sticky", 32'(pre_err), 32'h1);

        // No preamble: every byte forwarded, first key is the seed.
        make_packet(5'h1E, 5'h01, 0, -1);
        do_cfg(5'h1E, 5'h01, 0);
        run_packet(32, -1);
        drain();
        check("t3_beats", 32'(beats), 32'd32);
        check("t3_first_byte", 32'(first_byte), 32'(enc[0] ^ 8'h01));

        // Back-pressure window mid-payload.
        make_packet(5'h1E, 5'h01, 7, -1);
        do_cfg(5'h1E, 5'h01, 7);
        run_packet(32, 15);
        drain();
        check("t4_beats", 32'(beats), 32'd25);

        // Reload at byte 12 with a new seed.
        make_packet(5'h1E, 5'h01, 7, -1);
        do_cfg(5'h1E, 5'h01, 7);
        run_packet(12, -1);
        make_packet(5'h1E, 5'h0B, 7, -1);
        do_cfg(5'h1E, 5'h0B, 7);
        tick();
        check("t5_plain_valid", 32'(plain_valid), 32'h0);
        check("t5_byte_count", 32'(byte_count), 32'h0);
        run_packet(32, -1);
        drain();
        check("t5_beats", 32'(beats), 32'd25);

        // Reset during payload.
        make_packet(5'h1E, 5'h01, 7, -1);
        do_cfg(5'h1E, 5'h01, 7);
        run_packet(20, -1);
        rst = 1'b1; enc_valid = 1'b1; plain_ready = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_plain_byte", 32'(plain_byte), 32'h0);
        check("t6_enc_ready", 32'(enc_ready), 32'h0);

        // Random configurations.
        for (int k = 0; k < 6; k++) begin
            int taps, seed, pl, corrupt;
            taps = int'($urandom_range(0, 31));
            seed = int'($urandom_range(1, 31));
            pl   = int'($urandom_range(0, 15));
            corrupt = ($urandom % 2 != 0 && pl > 0) ? int'($urandom_range(0, pl - 1)) : -1;
            make_packet(taps, seed, pl, corrupt);
            do_cfg(taps, seed, pl);
            run_packet(32, int'($urandom_range(16, 28)));
            drain();
            check("rnd_beats", 32'(beats), 32'(PKT_LEN - pl));
            check("rnd_pre_err", 32'(pre_err), 32'(corrupt >= 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lfsr_decrypt_rx.md
Name: lfsr_decrypt_rx

Overview:
Receive-side stage that sits directly downstream of the LFSR encryption datapath. It consumes the encrypted byte stream and regenerates the same 5-bit LFSR keystream from a loaded taps/seed/preamble-length configuration. It checks and strips the preamble, then emits the decrypted payload bytes on a valid/ready interface. It reports packet completion and preamble errors to the sequencer.

Parameters:
DW, 8, data byte width
LFSR_W, 5, LFSR state/taps width
PKT_LEN, 32, total bytes per packet (preamble + payload)
PRE_CHAR, 8'h5F, expected plaintext preamble character
CW, 6, byte counter width (must hold PKT_LEN)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cfg_load  in  1  capture cfg_* and (re)start packet reception
cfg_taps  in  LFSR_W  LFSR feedback tap pattern
cfg_seed  in  LFSR_W  LFSR starting state
cfg_pre_len  in  4  preamble length in bytes, 0..15
enc_valid  in  1  enc_byte is valid
enc_byte  in  DW  encrypted byte from encryption stage
enc_ready  out  1  block accepts enc_byte this cycle
plain_valid  out  1  plain_byte holds a decrypted payload byte
plain_ready  in  1  downstream accepts plain_byte
plain_byte  out  DW  decrypted payload byte
byte_count  out  CW  bytes consumed in current packet
pre_err  out  1  sticky: a preamble byte decrypted to something other than PRE_CHAR
pkt_done  out  1  one-cycle pulse when the last packet byte is consumed
busy  out  1  high in PREAMBLE or PAYLOAD

Behaviour:
- Reset values: state=IDLE. enc_ready=0, plain_valid=0, plain_byte=0, byte_count=0, pre_err=0, pkt_done=0, busy=0. Taps/seed/pre_len registers=0.
- Keystream: key = {3'b0, lfsr}. Decrypted byte = enc_byte ^ key.
- LFSR update: next = {lfsr[3:0], ^(lfsr & taps)}. It advances only on an accepted byte (enc_valid && enc_ready). cfg_load loads lfsr=cfg_seed.
- Accept: enc_ready = busy && (!plain_valid || plain_ready). Preamble bytes are accepted under the same rule; there is no independent preamble path.
- FSM states: IDLE, PREAMBLE, PAYLOAD.
  - IDLE: waits for cfg_load.
  - cfg_load: captures cfg_*, clears byte_count and pre_err, then goes to PREAMBLE, or to PAYLOAD if cfg_pre_len==0.
  - PREAMBLE: each accepted byte increments byte_count. If the decrypted byte != PRE_CHAR, pre_err is set (sticky). Preamble bytes are not forwarded. When the accepted byte makes byte_count==pre_len, go to PAYLOAD.
  - PAYLOAD: each accepted byte loads plain_byte with the decrypted value and sets plain_valid the next cycle; latency is 1 cycle. byte_count increments. On the accepted byte making byte_count==PKT_LEN: pkt_done pulses for 1 cycle, go to IDLE.
- plain_valid clears on plain_ready when no new payload byte is accepted the same cycle. Simultaneous pop and push keeps plain_valid=1 with new data.
- The output register is single entry. Back-pressure (plain_ready=0) drops enc_ready the same cycle, so no byte is lost.
- cfg_load in any state takes priority: it aborts the current packet, drops plain_valid, applies the load, and does not pulse pkt_done.
- pre_len > PKT_LEN cannot occur (4-bit max 15 < 32). The byte_count comparison is exact-equal, with no wrap.
- In IDLE, byte_count, pre_err and the config registers hold until the next cfg_load. Reset mid-packet returns all outputs to reset values on the next edge.

Decomposition:
- Shared package lfsr_pkg: LFSR_W, PKT_LEN, PRE_CHAR, a state enum type rx_state_t, and a function for the LFSR next-state.
- One sub-module: the existing lfsr5 (en = accept, init = cfg_load, taps, start = cfg_seed). No other instances; the FSM, counter and output register live in lfsr_decrypt_rx.

Test Plan:
1. Config taps=5'h1E, seed=5'h01, pre_len=7. Drive the stream produced by the encryptor for PRE_CHAR×7 + 25 payload bytes; first enc bytes are 8'h5E, 8'h5D -> pre_err=0, exactly 25 plain_valid beats matching the original payload, pkt_done pulses once when byte_count reaches 32.
2. Same config, but the 3rd preamble byte is corrupted by XOR 8'h01 -> pre_err=1 and stays set; payload still decrypts correctly; pkt_done still fires.
3. pre_len=0 -> all 32 bytes are forwarded; the first plain_byte equals enc_byte ^ 8'h01 with seed 5'h01.
4. Hold plain_ready=0 for 5 cycles mid-payload with enc_valid=1 -> enc_ready=0 throughout, plain_byte stable, LFSR not advanced; on release, no byte is lost or duplicated.
5. Assert cfg_load at byte_count=12 with a new seed -> plain_valid drops, byte_count=0, no pkt_done, and the new packet decrypts with the new keystream.
6. Assert rst during PAYLOAD -> the next cycle shows all outputs at reset values, and enc_ready=0 until cfg_load.
